// File: rtl/predictor_pkg.sv
// Shared defaults and counter helpers for branch predictors.
// Exports default widths and the saturating next-value function.
package predictor_pkg;

    localparam int PC_W_DEF   = 8;
    localparam int IDX_W_DEF  = 4;
    localparam int HIST_W_DEF = 4;
    localparam int CTR_W_DEF  = 2;
    localparam int STAT_W_DEF = 16;
    localparam int CTR_W_MAX  = 4;

    // Next value of a width-bit saturating counter held in the low bits
    // of ctr; clamps at 0 and at 2**width-1 instead of wrapping.
    function automatic logic [CTR_W_MAX-1:0] sat_next(
        input logic [CTR_W_MAX-1:0] ctr,
        input logic                 up,
        input int unsigned          width
    );
        logic [CTR_W_MAX-1:0] top;
        top = CTR_W_MAX'((32'd1 << width) - 32'd1);
        if (up) begin
            return (ctr >= top) ? ctr : ctr + CTR_W_MAX'(1);
        end
        return (ctr == '0) ? ctr : ctr - CTR_W_MAX'(1);
    endfunction

endpackage

// File: rtl/sat_ctr_table.sv
// Table of saturating direction counters: async read, trained write.
// Ports: clk, rst_n, rd_idx -> rd_ctr, wr_en/wr_idx/wr_up train one entry.
module sat_ctr_table
    import predictor_pkg::*;
#(
    parameter int             IDX_W    = IDX_W_DEF,
    parameter int             CTR_W    = CTR_W_DEF,
    parameter logic [CTR_W-1:0] CTR_INIT = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_up
);

    localparam int N = 2 ** IDX_W;

    logic [CTR_W-1:0] ctr_q [N];
    logic [CTR_W-1:0] wr_next;

    // Read is combinational from current state, so a same-cycle write
    // is seen only from the next cycle on.
    assign rd_ctr = ctr_q[rd_idx];

    assign wr_next = CTR_W'(sat_next(CTR_W_MAX'(ctr_q[wr_idx]), wr_up, CTR_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= wr_next;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: pc XOR global history indexes a counter table.
// Ports: req_* -> pred_* one cycle later, upd_* trains, stat_* counts updates.
module gshare_predictor
    import predictor_pkg::*;
#(
    parameter int               PC_W     = PC_W_DEF,
    parameter int               IDX_W    = IDX_W_DEF,
    parameter int               HIST_W   = HIST_W_DEF,
    parameter int               CTR_W    = CTR_W_DEF,
    parameter logic [CTR_W-1:0] CTR_INIT = '1,
    parameter int               STAT_W   = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [PC_W-1:0]   req_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic [STAT_W-1:0] stat_upd,
    output logic [STAT_W-1:0] stat_miss
);

    if (HIST_W < 0 || HIST_W > IDX_W || CTR_W < 2 || CTR_W > CTR_W_MAX
        || PC_W < IDX_W || STAT_W < 1) begin : g_bad_params
        $error("gshare_predictor: illegal parameter combination");
    end

    logic [IDX_W-1:0] hist_ext;
    logic [IDX_W-1:0] idx;
    logic [CTR_W-1:0] rd_ctr;
    logic             unused_ok;

    // Upper pc bits do not take part in indexing.
    assign unused_ok = ^req_pc;

    if (HIST_W == 0) begin : g_bimodal
        assign hist_ext = '0;
    end else begin : g_hist
        logic [HIST_W-1:0] ghr;

        // Non-speculative: history only moves on resolved updates.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ghr <= '0;
            end else if (upd_valid) begin
                ghr <= HIST_W'({ghr, upd_taken});
            end
        end

        assign hist_ext = IDX_W'(ghr);
    end

    assign idx = req_pc[IDX_W-1:0] ^ hist_ext;

    sat_ctr_table #(
        .IDX_W    (IDX_W),
        .CTR_W    (CTR_W),
        .CTR_INIT (CTR_INIT)
    ) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (idx),
        .rd_ctr (rd_ctr),
        .wr_en  (upd_valid),
        .wr_idx (upd_idx),
        .wr_up  (upd_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_idx   <= '0;
        end else begin
            pred_valid <= req_valid;
            if (req_valid) begin
                pred_taken <= rd_ctr[CTR_W-1];
                pred_idx   <= idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_upd  <= '0;
            stat_miss <= '0;
        end else if (upd_valid) begin
            if (stat_upd != '1) begin
                stat_upd <= stat_upd + STAT_W'(1);
            end
            if (upd_pred != upd_taken && stat_miss != '1) begin
                stat_miss <= stat_miss + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed vector bench for gshare_predictor (defaults plus a STAT_W=4 copy).
// Table of per-cycle vectors, then hand sequences for reset and statistics.
module tb_gshare_predictor;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [7:0] req_pc;
    logic       upd_valid;
    logic [3:0] upd_idx;
    logic       upd_taken;
    logic       upd_pred;

    logic        pred_valid;
    logic        pred_taken;
    logic [3:0]  pred_idx;
    logic [15:0] stat_upd;
    logic [15:0] stat_miss;

    logic        d4_pred_valid;
    logic        d4_pred_taken;
    logic [3:0]  d4_pred_idx;
    logic [3:0]  d4_stat_upd;
    logic [3:0]  d4_stat_miss;

    int n_vec;
    int n_miss;

    gshare_predictor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .upd_pred   (upd_pred),
        .stat_upd   (stat_upd),
        .stat_miss  (stat_miss)
    );

    gshare_predictor #(.STAT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .pred_valid (d4_pred_valid),
        .pred_taken (d4_pred_taken),
        .pred_idx   (d4_pred_idx),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .upd_pred   (upd_pred),
        .stat_upd   (d4_stat_upd),
        .stat_miss  (d4_stat_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rv;
        logic [7:0] pc;
        logic       uv;
        logic [3:0] ui;
        logic       ut;
        logic       epv;
        logic       ept;
        logic [3:0] eidx;
    } vec_t;

    localparam int NV = 29;
    vec_t vt [NV];

    function automatic vec_t mk(input logic rv, input logic [7:0] pc,
                                input logic uv, input logic [3:0] ui,
                                input logic ut, input logic epv,
                                input logic ept, input logic [3:0] eidx);
        vec_t v;
        v.rv = rv; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut;
        v.epv = epv; v.ept = ept; v.eidx = eidx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [7:0] pc,
                         input logic uv, input logic [3:0] ui,
                         input logic ut, input logic up);
        req_valid = rv;
        req_pc    = pc;
        upd_valid = uv;
        upd_idx   = ui;
        upd_taken = ut;
        upd_pred  = up;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        drive(0, 8'h00, 0, 4'h0, 0, 0);

        // Fields: rv pc uv ui ut | expected pv pt idx after the edge.
        vt[0]  = mk(1, 8'h05, 0, 4'h0, 0, 1, 1, 4'h5);
        vt[1]  = mk(0, 8'h00, 0, 4'h0, 0, 0, 1, 4'h5);
        vt[2]  = mk(0, 8'h00, 1, 4'h3, 0, 0, 1, 4'h5);
        vt[3]  = mk(0, 8'h00, 1, 4'h3, 0, 0, 1, 4'h5);
        vt[4]  = mk(0, 8'h00, 1, 4'h3, 0, 0, 1, 4'h5);
        vt[5]  = mk(0, 8'h00, 1, 4'h3, 0, 0, 1, 4'h5);
        vt[6]  = mk(0, 8'h00, 1, 4'h3, 0, 0, 1, 4'h5);
        vt[7]  = mk(1, 8'h03, 0, 4'h0, 0, 1, 0, 4'h3);
        vt[8]  = mk(0, 8'h00, 1, 4'h3, 0, 0, 0, 4'h3);
        vt[9]  = mk(1, 8'h03, 0, 4'h0, 0, 1, 0, 4'h3);
        vt[10] = mk(0, 8'h00, 1, 4'h3, 1, 0, 0, 4'h3);
        vt[11] = mk(0, 8'h00, 1, 4'h3, 1, 0, 0, 4'h3);
        vt[12] = mk(0, 8'h00, 1, 4'h3, 1, 0, 0, 4'h3);
        vt[13] = mk(1, 8'h04, 0, 4'h0, 0, 1, 1, 4'h3);
        vt[14] = mk(0, 8'h00, 1, 4'h3, 1, 0, 1, 4'h3);
        vt[15] = mk(1, 8'h0C, 0, 4'h0, 0, 1, 1, 4'h3);
        vt[16] = mk(0, 8'h00, 1, 4'h3, 0, 0, 1, 4'h3);
        vt[17] = mk(1, 8'h0D, 0, 4'h0, 0, 1, 1, 4'h3);
        vt[18] = mk(0, 8'h00, 1, 4'h3, 0, 0, 1, 4'h3);
        vt[19] = mk(1, 8'h0F, 0, 4'h0, 0, 1, 0, 4'h3);
        vt[20] = mk(0, 8'h00, 1, 4'h8, 0, 0, 0, 4'h3);
        vt[21] = mk(0, 8'h00, 1, 4'h8, 1, 0, 0, 4'h3);
        vt[22] = mk(0, 8'h00, 1, 4'h8, 0, 0, 0, 4'h3);
        vt[23] = mk(0, 8'h00, 1, 4'h8, 1, 0, 0, 4'h3);
        vt[24] = mk(1, 8'h0F, 0, 4'h0, 0, 1, 1, 4'hA);
        vt[25] = mk(1, 8'h06, 0, 4'h0, 0, 1, 0, 4'h3);
        vt[26] = mk(0, 8'h00, 1, 4'h2, 0, 0, 0, 4'h3);
        vt[27] = mk(1, 8'h08, 1, 4'h2, 0, 1, 1, 4'h2);
        vt[28] = mk(1, 8'h06, 0, 4'h0, 0, 1, 0, 4'h2);

        // Reset state while rst_n is held low.
        #7;
        chk("reset_pred", {26'd0, pred_valid, pred_taken, pred_idx}, 32'd0);
        chk("reset_stat", {stat_upd, stat_miss}, 32'd0);

        // Release on a falling edge and issue the first request at once.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            drive(vt[i].rv, vt[i].pc, vt[i].uv, vt[i].ui, vt[i].ut, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                {26'd0, pred_valid, pred_taken, pred_idx},
                {26'd0, vt[i].epv, vt[i].ept, vt[i].eidx});
        end

        // Reset between a request and its response.
        @(negedge clk);
        drive(1, 8'h03, 0, 4'h0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_async", {26'd0, pred_valid, pred_taken, pred_idx}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_no_pv", {31'd0, pred_valid}, 32'd0);
        chk("midrst_stat", {stat_upd, stat_miss}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 8'h03, 0, 4'h0, 0, 0);
        @(posedge clk);
        #1;
        chk("post_rst_init", {26'd0, pred_valid, pred_taken, pred_idx},
            {26'd0, 1'b1, 1'b1, 4'h3});

        // Ten updates, mispredicted at steps 2, 5 and 7.
        for (int i = 0; i < 10; i++) begin
            logic t;
            logic m;
            t = 1'(i % 2);
            m = (i == 2 || i == 5 || i == 7);
            @(negedge clk);
            drive(0, 8'h00, 1, 4'h0, t, m ? ~t : t);
        end
        @(negedge clk);
        drive(0, 8'h00, 0, 4'h0, 0, 0);
        chk("stat_upd_10", {16'd0, stat_upd}, 32'd10);
        chk("stat_miss_3", {16'd0, stat_miss}, 32'd3);
        chk("stat4_upd_10", {28'd0, d4_stat_upd}, 32'd10);

        // Ten more, all correct: the 4-bit copy pins at 15.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(0, 8'h00, 1, 4'h1, 1, 1);
        end
        @(negedge clk);
        drive(0, 8'h00, 0, 4'h0, 0, 0);
        chk("stat_upd_20", {16'd0, stat_upd}, 32'd20);
        chk("stat_miss_hold", {16'd0, stat_miss}, 32'd3);
        chk("stat4_upd_sat", {28'd0, d4_stat_upd}, 32'd15);
        chk("stat4_miss_3", {28'd0, d4_stat_miss}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameter PC_W, default 8, branch address width in bits.
REQ-002 Parameter IDX_W, default 4, table index width; the table holds 2**IDX_W entries.
REQ-003 Parameter HIST_W, default 4, global history length in bits; legal range 0..IDX_W, where 0 selects pure bimodal indexing.
REQ-004 Parameter CTR_W, default 2, saturating counter width; legal range 2..4.
REQ-005 Parameter CTR_INIT, default all ones (strongly taken), reset value of every table counter.
REQ-006 Parameter STAT_W, default 16, width of each statistics counter.
REQ-007 clk  in  1  sole clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 req_valid  in  1  prediction request strobe.
REQ-010 req_pc  in  PC_W  branch address of the request.
REQ-011 pred_valid  out  1  prediction outputs are valid this cycle.
REQ-012 pred_taken  out  1  predicted direction, 1 = taken.
REQ-013 pred_idx  out  IDX_W  table index used for the prediction; the caller returns it with the update.
REQ-014 upd_valid  in  1  resolved-branch update strobe.
REQ-015 upd_idx  in  IDX_W  index to train, as previously returned on pred_idx.
REQ-016 upd_taken  in  1  resolved direction, 1 = taken.
REQ-017 upd_pred  in  1  direction that was originally predicted for this branch.
REQ-018 stat_upd  out  STAT_W  number of updates applied.
REQ-019 stat_miss  out  STAT_W  number of updates where upd_pred != upd_taken.

Function
REQ-020 Index = req_pc[IDX_W-1:0] XOR {zeros, ghr[HIST_W-1:0]}, with the history right-aligned; when HIST_W = 0 the index is req_pc[IDX_W-1:0].
REQ-021 Latency is one cycle: a request in cycle N produces pred_valid = 1 in cycle N+1, with pred_taken = MSB of the indexed counter and pred_idx = the computed index.
REQ-022 pred_valid = 0 in any cycle not preceded by req_valid; pred_taken and pred_idx hold their last values in that case.
REQ-023 Training on upd_valid: taken increments the counter at upd_idx, saturating at 2**CTR_W-1; not-taken decrements it, saturating at 0; no wrap-around is permitted.
REQ-024 On upd_valid, ghr <= {ghr[HIST_W-2:0], upd_taken}; history is non-speculative and changes only on update.
REQ-025 When req_valid and upd_valid occur in the same cycle, including to the same index, the request reads the counter and the ghr values from before the update (read-before-write); the update still takes effect.
REQ-026 stat_upd increments on every upd_valid; stat_miss increments on upd_valid when upd_pred != upd_taken; both saturate at all ones.
REQ-027 Only table entry upd_idx changes on an update; all other entries hold.

Reset
REQ-028 Assertion of rst_n = 0 immediately clears pred_valid, pred_taken, pred_idx, ghr, stat_upd and stat_miss to 0, and sets every table counter to CTR_INIT.
REQ-029 Reset asserted mid-operation discards any in-flight prediction: no pred_valid is produced for a request in the cycle reset asserts.
REQ-030 The first request is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package predictor_pkg shall hold the default parameter constants and a function for the saturating next-counter value, shared with other predictors.
REQ-032 One sub-module, sat_ctr_table, shall own the counter array, the read port and the training write port; ghr, indexing, output registers and statistics stay in gshare_predictor.
REQ-033 Illegal parameter combinations (HIST_W > IDX_W, or CTR_W outside 2..4) shall stop elaboration.

Verification
REQ-034 Reset defaults: after reset, request pc=0x05 -> next cycle pred_valid=1, pred_taken=1, pred_idx=0x5 (ghr=0).
REQ-035 Saturation: five not-taken updates to idx 3 -> counter 0, pred_taken=0; a further not-taken update leaves it 0; three taken updates -> 3; a fourth taken update leaves it 3.
REQ-036 History hashing: updates with upd_taken = 1, 0, 1 -> ghr=4'b0101; request pc=0x0F -> pred_idx=0xA.
REQ-037 Collision: same-cycle request and not-taken update to idx 2, counter 2'b10 -> pred_taken=1; a request in the following cycle -> pred_taken=0.
REQ-038 Statistics: 10 updates, 3 of them with upd_pred != upd_taken -> stat_upd=10, stat_miss=3; with STAT_W=4, 20 updates -> stat_upd=15.
REQ-039 Mid-operation reset: rst_n pulled low between a request and its response -> pred_valid stays 0, and the table returns to CTR_INIT.
